alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked ALU for the pipelined MIPS32 datapath.
//  Keeps the single-cycle ops (AND/OR/ADD/SUB/SLT) and adds NOR, plus iterative unsigned MULU and DIVU.
//  Ops issue on a valid/ready input port; results retire on a valid/ready output port.
//  The EX stage stalls on in_ready=0 while a MULU or DIVU is iterating.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4)
//  CNT_W  6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      operands and op are valid this cycle
//  in_ready   out  1      block accepts an op this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  ALU_Ctrl   in   4      op select (encoding below)
//  out_valid  out  1      result, hi, zero, ov and dz are valid
//  out_ready  in   1      consumer takes the result this cycle
//  result     out  WIDTH  main result; product low half for MULU; quotient for DIVU
//  hi         out  WIDTH  product high half for MULU; remainder for DIVU; 0 for all other ops
//  zero       out  1      result == 0
//  ov         out  1      signed overflow of ADD/SUB; 0 for all other ops
//  dz         out  1      DIVU with b == 0
// BEHAVIOUR
//  Encoding: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR, 1000 MULU, 1010 DIVU.
//  Any other code executes as ADD.
//  Arithmetic: all results are modulo 2**WIDTH.
//   - ADD/SUB ov: carry into MSB XOR carry out of MSB.
//   - SLT: result = {0...,1} when $signed(a) < $signed(b), else 0.
//  Accept: a transfer occurs on any rising edge where in_valid && in_ready.
//   - a, b and ALU_Ctrl are captured on that edge; later input changes are ignored.
//  in_ready = !reset && (state==IDLE || (state==DONE && out_ready)).
//  FSM: IDLE -> accept -> DONE for single-cycle ops, BUSY for MULU/DIVU.
//   - BUSY: one shift-add or restoring-divide step per cycle; cnt counts down from WIDTH.
//   - BUSY -> DONE on the step where cnt==1.
//   - DONE: out_valid=1; outputs stay stable until out_valid && out_ready.
//   - DONE + out_ready with no new accept -> IDLE.
//   - DONE + out_ready with a new accept -> DONE or BUSY, same cycle (back-to-back, no bubble).
//  Latency, for an op accepted at edge E:
//   - single-cycle ops: out_valid=1 in the cycle after E.
//   - MULU/DIVU: out_valid=1 in the cycle after edge E+WIDTH.
//  Throughput: 1 op/cycle for single-cycle ops; 1 op per WIDTH+1 cycles for MULU/DIVU.
//  DIVU by zero: no iteration; DONE after 1 cycle with result = all ones, hi = a, dz = 1.
//  Backpressure: out_ready=0 in DONE holds result/hi/flags and keeps in_ready=0.
//  Reset, on any clock edge with reset=1 (including mid-BUSY or mid-DONE):
//   - state=IDLE; result, hi, zero, ov, dz, out_valid, cnt all 0.
//   - the in-flight op is discarded with no output.
//   - in_ready=0 while reset=1, and 1 in the first cycle after reset deasserts.
//  zero, ov and dz are registered together with result; there is no combinational input-to-output path.
// TESTING
//  1. Reset mid-operation: MULU accepted, reset high at step 10 -> next cycle state IDLE, out_valid=0, result=0, in_ready=1 after release.
//  2. Single-cycle ops: ADD 0x7FFFFFFF+1 -> result 0x80000000, ov=1, zero=0, 1 cycle;
//     SUB 5-5 -> result 0, zero=1, ov=0; SLT 0xFFFFFFFF vs 1 -> result 1.
//  3. MULU 0xFFFFFFFF*0xFFFFFFFF -> hi 0xFFFFFFFE, result 0x00000001;
//     out_valid exactly 32 cycles after accept; in_ready=0 throughout.
//  4. DIVU 100/7 -> result 14, hi 2, dz=0;
//     DIVU 9/0 -> result 0xFFFFFFFF, hi 9, dz=1, 1 cycle.
//  5. Backpressure and back-to-back: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0;
//     then 3 back-to-back ADDs with out_ready=1 -> 3 results on 3 consecutive cycles, in order.
//  6. Unknown code 0x3 with a=2, b=3 -> result 5 (ADD default), hi 0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked MIPS32 ALU.
// Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR) retire one cycle after accept;
// MULU (shift-add) and DIVU (restoring) iterate one bit per cycle for WIDTH cycles.
//
// Handshake: a transfer happens on a rising edge when valid && ready are both
// high on that port. The producer holds valid and payload until that edge.
// The consumer may drop ready at any time. Outputs stay stable while
// out_valid=1 and out_ready=0.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALU_Ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ov,
    output logic             dz,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1010;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] w_hi;   // product high half / partial remainder
    logic [WIDTH-1:0] w_lo;   // multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0] w_b;    // multiplicand / divisor
    logic             w_div;  // 1 while iterating a DIVU

    assign state_dbg = state;
    assign in_ready  = !reset && (state == IDLE || (state == DONE && out_ready));

    logic accept;
    assign accept = in_valid && in_ready;

    // Single-cycle datapath on the live inputs; its result is registered on accept.
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;
    logic             add_ov;
    logic             slt_lt;
    logic [WIDTH-1:0] sc_result;
    logic             sc_ov;
    always_comb begin
        is_sub    = (ALU_Ctrl == OP_SUB);
        b_eff     = is_sub ? ~b : b;
        sum_full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        // carry into MSB is a^b^sum at that bit; xor with carry out
        add_ov    = (a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_full[WIDTH-1]) ^ sum_full[WIDTH];
        slt_lt    = $signed(a) < $signed(b);
        sc_result = sum_full[WIDTH-1:0];
        sc_ov     = add_ov;
        case (ALU_Ctrl)
            OP_AND: begin sc_result = a & b;    sc_ov = 1'b0; end
            OP_OR:  begin sc_result = a | b;    sc_ov = 1'b0; end
            OP_NOR: begin sc_result = ~(a | b); sc_ov = 1'b0; end
            OP_SLT: begin sc_result = {{(WIDTH-1){1'b0}}, slt_lt}; sc_ov = 1'b0; end
            default: ; // ADD, SUB and all unlisted codes use the adder
        endcase
    end

    // One iteration step for the multiplier and the restoring divider.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    always_comb begin
        mul_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_b} : {(WIDTH+1){1'b0}});
        div_shift = {w_hi, w_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, w_b};
        // when div_ge holds the true difference is below 2**WIDTH
        div_diff  = div_shift[WIDTH-1:0] - w_b;
        if (w_div) begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {w_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], w_lo[WIDTH-1:1]};
        end
    end

    // FSM, iteration registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            w_hi      <= '0;
            w_lo      <= '0;
            w_b       <= '0;
            w_div     <= 1'b0;
            result    <= '0;
            hi        <= '0;
            zero      <= 1'b0;
            ov        <= 1'b0;
            dz        <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            if (ALU_Ctrl == OP_DIVU && b == '0) begin
                state     <= DONE;
                out_valid <= 1'b1;
                result    <= '1;
                hi        <= a;
                zero      <= 1'b0;
                ov        <= 1'b0;
                dz        <= 1'b1;
            end else if (ALU_Ctrl == OP_MULU || ALU_Ctrl == OP_DIVU) begin
                state     <= BUSY;
                out_valid <= 1'b0;
                cnt       <= CNT_W'(WIDTH);
                w_hi      <= '0;
                w_lo      <= a;
                w_b       <= b;
                w_div     <= (ALU_Ctrl == OP_DIVU);
            end else begin
                state     <= DONE;
                out_valid <= 1'b1;
                result    <= sc_result;
                hi        <= '0;
                zero      <= (sc_result == '0);
                ov        <= sc_ov;
                dz        <= 1'b0;
            end
        end else begin
            case (state)
                BUSY: begin
                    w_hi <= step_hi;
                    w_lo <= step_lo;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= step_lo;
                        hi        <= step_hi;
                        zero      <= (step_lo == '0);
                        ov        <= 1'b0;
                        dz        <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed test of alu_seq with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling edge.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   ALU_Ctrl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic         zero;
    logic         ov;
    logic         dz;
    logic [1:0]   state_dbg;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ALU_Ctrl(ALU_Ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .hi(hi), .zero(zero), .ov(ov), .dz(dz),
        .state_dbg(state_dbg)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // driver: present one op at the falling edge, hold it through the next rising edge
    task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        ALU_Ctrl = op; a = av; b = bv; in_valid = 1'b1;
        chk("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; ALU_Ctrl = 4'($urandom_range(0, 15));
    endtask

    // driver: issue an iterative op and count edges until out_valid, bounded
    task automatic issue_iter(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                              output int edges, output int ir_bad);
        ALU_Ctrl = op; a = av; b = bv; in_valid = 1'b1;
        chk("in_ready_before_iter", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        edges = 0; ir_bad = 0;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a = $urandom; b = $urandom;
            if (out_valid) break;
            if (in_ready) ir_bad++;
            @(posedge clk);
            edges++;
        end
    endtask

    initial begin
        int edges;
        int ir_bad;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; ALU_Ctrl = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
        chk("reset_state", {30'b0, state_dbg}, 32'd0);
        reset = 1'b0;
        #1;
        chk("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

        // single-cycle ops
        issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
        chk("add_valid", {31'b0, out_valid}, 32'd1);
        chk("add_result", result, 32'h8000_0000);
        chk("add_ov", {31'b0, ov}, 32'd1);
        chk("add_zero", {31'b0, zero}, 32'd0);
        chk("add_hi", hi, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("idle_after_take", {31'b0, out_valid}, 32'd0);

        issue(4'b0110, 32'd5, 32'd5);
        chk("sub_result", result, 32'd0);
        chk("sub_zero", {31'b0, zero}, 32'd1);
        chk("sub_ov", {31'b0, ov}, 32'd0);
        @(posedge clk); @(negedge clk);

        issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
        chk("slt_result", result, 32'd1);
        @(posedge clk); @(negedge clk);

        issue(4'b1100, 32'h0F0F_0000, 32'h0000_00FF);
        chk("nor_result", result, 32'hF0F0_FF00);
        @(posedge clk); @(negedge clk);

        issue(4'b0110, 32'h8000_0000, 32'd1);
        chk("sub_ov_result", result, 32'h7FFF_FFFF);
        chk("sub_ov_flag", {31'b0, ov}, 32'd1);
        @(posedge clk); @(negedge clk);

        issue(4'b0011, 32'd2, 32'd3);
        chk("unk_result", result, 32'd5);
        chk("unk_hi", hi, 32'd0);
        @(posedge clk); @(negedge clk);

        // MULU
        issue_iter(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, ir_bad);
        chk("mulu_latency", 32'(edges), 32'd32);
        chk("mulu_in_ready_busy", 32'(ir_bad), 32'd0);
        chk("mulu_lo", result, 32'h0000_0001);
        chk("mulu_hi", hi, 32'hFFFF_FFFE);
        @(posedge clk); @(negedge clk);

        issue_iter(4'b1000, 32'd12345, 32'd1000, edges, ir_bad);
        chk("mulu2_lo", result, 32'd12345000);
        chk("mulu2_hi", hi, 32'd0);
        @(posedge clk); @(negedge clk);

        // DIVU
        issue_iter(4'b1010, 32'd100, 32'd7, edges, ir_bad);
        chk("divu_latency", 32'(edges), 32'd32);
        chk("divu_quot", result, 32'd14);
        chk("divu_rem", hi, 32'd2);
        chk("divu_dz", {31'b0, dz}, 32'd0);
        @(posedge clk); @(negedge clk);

        issue_iter(4'b1010, 32'd9, 32'd0, edges, ir_bad);
        chk("divz_latency", 32'(edges), 32'd0);
        chk("divz_result", result, 32'hFFFF_FFFF);
        chk("divz_hi", hi, 32'd9);
        chk("divz_dz", {31'b0, dz}, 32'd1);
        @(posedge clk); @(negedge clk);

        // reset mid-MULU, around step 10
        ALU_Ctrl = 4'b1000; a = 32'd77; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("mid_busy_state", {30'b0, state_dbg}, 32'd1);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("midrst_state", {30'b0, state_dbg}, 32'd0);
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("midrst_in_ready_rel", {31'b0, in_ready}, 32'd1);
        @(posedge clk); @(negedge clk);
        chk("midrst_no_output", {31'b0, out_valid}, 32'd0);

        // backpressure
        out_ready = 1'b0;
        issue(4'b0010, 32'd10, 32'd20);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_result", result, 32'd30);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk); @(negedge clk);
        end

        // back-to-back ADDs; 30 retires on the first edge
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            ALU_Ctrl = 4'b0010; a = 32'(i); b = 32'(i); in_valid = 1'b1;
            exp_q.push_back(32'(2 * i));
            #1;
            chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
            @(posedge clk); @(negedge clk);
            chk("b2b_valid", {31'b0, out_valid}, 32'd1);
            if (exp_q.size() > 0) chk("b2b_result", result, exp_q.pop_front());
        end
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("b2b_drained", {31'b0, out_valid}, 32'd0);
        chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
